// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   state_e   : arbiter FSM states
//   LEN_*     : access-size encodings used on request and memory ports
//   cmd_t     : latched command payload
//   len_bytes : number of bytes touched by a length code
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [LEN_W-1:0] LEN_NONE = 2'b00;
    localparam logic [LEN_W-1:0] LEN_BYTE = 2'b01;
    localparam logic [LEN_W-1:0] LEN_HALF = 2'b10;
    localparam logic [LEN_W-1:0] LEN_WORD = 2'b11;

    // Command held from acceptance until the response; access size is kept
    // in the memory length registers, not here.
    typedef struct packed {
        logic              we;
        logic              sgn;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              err;
    } cmd_t;

    function automatic logic [2:0] len_bytes(input logic [LEN_W-1:0] len);
        case (len)
            LEN_BYTE: len_bytes = 3'd1;
            LEN_HALF: len_bytes = 3'd2;
            LEN_WORD: len_bytes = 3'd4;
            default:  len_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick.
//   valid_i : per-requester request
//   last_i  : id of the requester served most recently
//   any_o   : at least one request present
//   win_o   : winning requester id (meaningful when any_o)
module dmem_arb_rr (
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       any_o,
    output logic       win_o
);

    // On contention the requester not served last wins; a lone requester always wins.
    always_comb begin
        any_o = |valid_i;
        win_o = 1'b0;
        if (valid_i == 2'b11) begin
            win_o = ~last_i;
        end else if (valid_i[1]) begin
            win_o = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core
// LSU (requester 0) and the debug/preload loader (requester 1).
// One command at a time: IDLE (arbitrate + latch) -> ACCESS (one memory
// cycle, grant pulse) -> RESP (response pulse) -> IDLE.
// Ports:
//   SYS_clk, SYS_reset_n             : clock, async active-low reset
//   REQ_valid/we/len/signed/addr/wdata : per-requester command (held until grant)
//   REQ_gnt                          : one-cycle accept pulse per requester
//   RSP_valid/rdata/err              : one-cycle response per requester
//   MEM_*                            : memory read/write controls and read data
// Build option: DMEM_ARB_CHECK_EN enables command legality checking
// (length code, alignment, range against MEM_DEPTH); rejected commands make
// no memory access and respond with RSP_err.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 100,
    parameter int unsigned N_REQ     = 2
) (
    input  logic                    SYS_clk,
    input  logic                    SYS_reset_n,
    input  logic [N_REQ-1:0]        REQ_valid,
    input  logic [N_REQ-1:0]        REQ_we,
    input  logic [LEN_W*N_REQ-1:0]  REQ_len,
    input  logic [N_REQ-1:0]        REQ_signed,
    input  logic [ADDR_W*N_REQ-1:0] REQ_addr,
    input  logic [DATA_W*N_REQ-1:0] REQ_wdata,
    output logic [N_REQ-1:0]        REQ_gnt,
    output logic [N_REQ-1:0]        RSP_valid,
    output logic [DATA_W-1:0]       RSP_rdata,
    output logic                    RSP_err,
    output logic [ADDR_W-1:0]       MEM_read_address,
    output logic [ADDR_W-1:0]       MEM_write_address,
    output logic [LEN_W-1:0]        MEM_read_length,
    output logic [LEN_W-1:0]        MEM_write_length,
    output logic                    MEM_read_signed,
    output logic [DATA_W-1:0]       MEM_write_data,
    input  logic [DATA_W-1:0]       MEM_read_data
);

    localparam int unsigned EXT_W = ADDR_W + 1;

    state_e             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic               id_q, id_d;
    logic               last_q, last_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [LEN_W-1:0]   wr_len_q, wr_len_d;
    logic [LEN_W-1:0]   rd_len_q, rd_len_d;

    logic               any_req_c;
    logic               win_c;
    cmd_t               sel_c;
    logic [LEN_W-1:0]   sel_len_c;

    dmem_arb_rr u_rr (
        .valid_i (REQ_valid),
        .last_i  (last_q),
        .any_o   (any_req_c),
        .win_o   (win_c)
    );

`ifdef DMEM_ARB_CHECK_EN
    // Illegal length code, misaligned half/word, or access past the end of memory.
    function automatic logic cmd_bad(input logic [LEN_W-1:0] len, input logic [ADDR_W-1:0] addr);
        logic [EXT_W-1:0] end_addr;
        end_addr = {1'b0, addr} + EXT_W'(len_bytes(len));
        cmd_bad  = (len == LEN_NONE)
                || (len == LEN_HALF && addr[0])
                || (len == LEN_WORD && addr[1:0] != 2'b00)
                || (end_addr > EXT_W'(MEM_DEPTH));
    endfunction
`else
    logic [31:0] unused_depth;
    assign unused_depth = 32'(MEM_DEPTH);
`endif

    // Winner's command fields.
    always_comb begin
        sel_c.we    = REQ_we[win_c];
        sel_c.sgn   = REQ_signed[win_c];
        sel_len_c   = win_c ? REQ_len[2*LEN_W-1:LEN_W]     : REQ_len[LEN_W-1:0];
        sel_c.addr  = win_c ? REQ_addr[2*ADDR_W-1:ADDR_W]  : REQ_addr[ADDR_W-1:0];
        sel_c.wdata = win_c ? REQ_wdata[2*DATA_W-1:DATA_W] : REQ_wdata[DATA_W-1:0];
`ifdef DMEM_ARB_CHECK_EN
        sel_c.err   = cmd_bad(sel_len_c, sel_c.addr);
`else
        sel_c.err   = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; every output is registered so the
    // memory lengths are high only while the FSM sits in ACCESS.
    always_comb begin
        cmd_d       = cmd_q;
        id_d        = id_q;
        last_d      = last_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rdata_d     = '0;
        err_d       = 1'b0;
        wr_len_d    = LEN_NONE;
        rd_len_d    = LEN_NONE;
        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    cmd_d        = sel_c;
                    id_d         = win_c;
                    gnt_d[win_c] = 1'b1;
                    if (!sel_c.err) begin
                        if (sel_c.we) wr_len_d = sel_len_c;
                        else          rd_len_d = sel_len_c;
                    end
                end
            end
            ACCESS: begin
                rsp_valid_d[id_q] = 1'b1;
                err_d             = cmd_q.err;
                if (!cmd_q.we && !cmd_q.err) rdata_d = MEM_read_data;
            end
            RESP: begin
                last_d = id_q;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            cmd_q       <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            wr_len_q    <= LEN_NONE;
            rd_len_q    <= LEN_NONE;
        end else begin
            cmd_q       <= cmd_d;
            id_q        <= id_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wr_len_q    <= wr_len_d;
            rd_len_q    <= rd_len_d;
        end
    end

    assign REQ_gnt           = gnt_q;
    assign RSP_valid         = rsp_valid_q;
    assign RSP_rdata         = rdata_q;
    assign RSP_err           = err_q;
    assign MEM_read_address  = cmd_q.addr;
    assign MEM_write_address = cmd_q.addr;
    assign MEM_read_length   = rd_len_q;
    assign MEM_write_length  = wr_len_q;
    assign MEM_read_signed   = cmd_q.sgn;
    assign MEM_write_data    = cmd_q.wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a big-endian byte memory model.
module tb_dmem_arbiter;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset_n;
    logic [1:0]  REQ_valid, REQ_we, REQ_signed, REQ_gnt, RSP_valid;
    logic [3:0]  REQ_len;
    logic [63:0] REQ_addr, REQ_wdata;
    logic [31:0] RSP_rdata, MEM_read_address, MEM_write_address, MEM_write_data, MEM_read_data;
    logic        RSP_err, MEM_read_signed;
    logic [1:0]  MEM_read_length, MEM_write_length;

    always #5 SYS_clk = ~SYS_clk;

    dmem_arbiter #(.MEM_DEPTH(100), .N_REQ(2)) dut (
        .SYS_clk           (SYS_clk),
        .SYS_reset_n       (SYS_reset_n),
        .REQ_valid         (REQ_valid),
        .REQ_we            (REQ_we),
        .REQ_len           (REQ_len),
        .REQ_signed        (REQ_signed),
        .REQ_addr          (REQ_addr),
        .REQ_wdata         (REQ_wdata),
        .REQ_gnt           (REQ_gnt),
        .RSP_valid         (RSP_valid),
        .RSP_rdata         (RSP_rdata),
        .RSP_err           (RSP_err),
        .MEM_read_address  (MEM_read_address),
        .MEM_write_address (MEM_write_address),
        .MEM_read_length   (MEM_read_length),
        .MEM_write_length  (MEM_write_length),
        .MEM_read_signed   (MEM_read_signed),
        .MEM_write_data    (MEM_write_data),
        .MEM_read_data     (MEM_read_data)
    );

    // Memory model: byte array, big-endian, write at clock edge, combinational read.
    logic [7:0] mem [0:255];
    logic [7:0] wa, ra;

    always @(posedge SYS_clk) begin
        wa = MEM_write_address[7:0];
        case (MEM_write_length)
            2'b01: mem[wa] <= MEM_write_data[7:0];
            2'b10: begin
                mem[wa]      <= MEM_write_data[15:8];
                mem[wa+8'd1] <= MEM_write_data[7:0];
            end
            2'b11: begin
                mem[wa]      <= MEM_write_data[31:24];
                mem[wa+8'd1] <= MEM_write_data[23:16];
                mem[wa+8'd2] <= MEM_write_data[15:8];
                mem[wa+8'd3] <= MEM_write_data[7:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        ra = MEM_read_address[7:0];
        case (MEM_read_length)
            2'b01: MEM_read_data = MEM_read_signed ? {{24{mem[ra][7]}}, mem[ra]} : {24'h0, mem[ra]};
            2'b10: MEM_read_data = MEM_read_signed ? {{16{mem[ra][7]}}, mem[ra], mem[ra+8'd1]}
                                                   : {16'h0, mem[ra], mem[ra+8'd1]};
            2'b11: MEM_read_data = {mem[ra], mem[ra+8'd1], mem[ra+8'd2], mem[ra+8'd3]};
            default: MEM_read_data = 32'h0;
        endcase
    end

    typedef struct {
        logic        id;
        logic        we;
        logic [1:0]  len;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [1:0] prev_gnt = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Per-cycle response checks at the falling edge.
    task automatic monitor();
        rsp_t r;
        check("rsp_latency", 32'(RSP_valid), 32'(prev_gnt));
        if (RSP_valid != 2'b00) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got valid=%b expected none", RSP_valid);
            end else begin
                r = sb.pop_front();
                check("rsp_id", 32'(RSP_valid), 32'(r.vld));
                check("rsp_rdata", RSP_rdata, r.rdata);
                check("rsp_err", 32'(RSP_err), 32'(r.err));
            end
        end
        check("wlen_outside_access", 32'(MEM_write_length != 2'b00 && REQ_gnt == 2'b00), 32'(0));
        check("rlen_outside_access", 32'(MEM_read_length != 2'b00 && REQ_gnt == 2'b00), 32'(0));
        prev_gnt = REQ_gnt;
    endtask

    task automatic tick();
        @(negedge SYS_clk);
        monitor();
        @(posedge SYS_clk);
        #1;
    endtask

    function automatic vec_t mk(input logic id, input logic we, input logic [1:0] len, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.id = id; v.we = we; v.len = len; v.sgn = sgn;
        v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        int idx;
        idx = int'(v.id);
        REQ_valid[idx]          = 1'b1;
        REQ_we[idx]             = v.we;
        REQ_signed[idx]         = v.sgn;
        REQ_len[idx*2 +: 2]     = v.len;
        REQ_addr[idx*32 +: 32]  = v.addr;
        REQ_wdata[idx*32 +: 32] = v.wdata;
    endtask

    // Bounded wait for the next grant; checks winner and cycles waited.
    task automatic wait_gnt(input logic [1:0] exp_gnt, input int exp_cyc, input string name);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (REQ_gnt == 2'b00 && c < 10);
        check({name, "_gnt"}, 32'(REQ_gnt), 32'(exp_gnt));
        check({name, "_gnt_latency"}, 32'(c), 32'(exp_cyc));
    endtask

    // In ACCESS: check memory controls, queue the expected response, release the request.
    task automatic accept(input vec_t v, input string name);
        logic [1:0] el_w, el_r;
        rsp_t r;
        el_w = (v.we && !v.exp_err) ? v.len : 2'b00;
        el_r = (!v.we && !v.exp_err) ? v.len : 2'b00;
        check({name, "_wlen"}, 32'(MEM_write_length), 32'(el_w));
        check({name, "_rlen"}, 32'(MEM_read_length), 32'(el_r));
        check({name, "_raddr"}, MEM_read_address, v.addr);
        check({name, "_waddr"}, MEM_write_address, v.addr);
        if (v.we) check({name, "_wdata"}, MEM_write_data, v.wdata);
        else      check({name, "_rsigned"}, 32'(MEM_read_signed), 32'(v.sgn));
        r.vld   = 2'b01 << v.id;
        r.rdata = v.exp_rdata;
        r.err   = v.exp_err;
        sb.push_back(r);
        REQ_valid[int'(v.id)] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        drive(v);
        wait_gnt(2'b01 << v.id, 1, name);
        accept(v, name);
        tick();
        tick();
    endtask

    task automatic check_zero(input string name);
        check({name, "_gnt"}, 32'(REQ_gnt), 32'(0));
        check({name, "_rsp_valid"}, 32'(RSP_valid), 32'(0));
        check({name, "_rdata"}, RSP_rdata, 32'(0));
        check({name, "_err"}, 32'(RSP_err), 32'(0));
        check({name, "_wlen"}, 32'(MEM_write_length), 32'(0));
        check({name, "_rlen"}, 32'(MEM_read_length), 32'(0));
        check({name, "_raddr"}, MEM_read_address, 32'(0));
        check({name, "_waddr"}, MEM_write_address, 32'(0));
        check({name, "_rsigned"}, 32'(MEM_read_signed), 32'(0));
        check({name, "_wdata"}, MEM_write_data, 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t a, b, v;
        logic [31:0] snap;

        SYS_reset_n = 1'b0;
        REQ_valid = '0; REQ_we = '0; REQ_signed = '0; REQ_len = '0; REQ_addr = '0; REQ_wdata = '0;

        //                id    we    len    sgn   addr    wdata          exp_rdata      err
        vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'hFFFFFFDE, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h000000DE, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h00001234, 32'h00000000, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 2'b10, 1'b1, 32'h20, 32'h0,        32'h00001234, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h21, 32'h00000080, 32'h00000000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b1, 32'h20, 32'h0,        32'h00001280, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b1, 32'h12, 32'h0,        32'hFFFFBEEF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h0000BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 2'b11, 1'b0, 32'd96, 32'hA5A50001, 32'h00000000, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 2'b11, 1'b0, 32'd96, 32'h0,        32'hA5A50001, 1'b0));
`ifdef DMEM_ARB_CHECK_EN
        vecs.push_back(mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h11, 32'hCAFEF00D, 32'h00000000, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 2'b11, 1'b0, 32'd98, 32'hCAFEF00D, 32'h00000000, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b1, 32'h21, 32'h0,        32'h00000000, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'h00000000, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 2'b01, 1'b0, 32'd98, 32'h0,        32'h00000000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'b01, 1'b0, 32'd99, 32'h0,        32'h00000001, 1'b0));
`endif

        repeat (3) @(posedge SYS_clk);
        #1;
        check_zero("reset");
        SYS_reset_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during the ACCESS cycle of a store.
        snap = {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]};
        v = mk(1'b0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b0);
        drive(v);
        wait_gnt(2'b01, 1, "rst_store");
        check("rst_store_wlen", 32'(MEM_write_length), 32'(2'b11));
        #2;
        SYS_reset_n = 1'b0;
        #1;
        check_zero("mid_access_reset");
        REQ_valid = '0;
        tick();
        tick();
        check("rst_mem_untouched", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, snap);
        SYS_reset_n = 1'b1;
        tick();
        run_vec(mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, snap, 1'b0), "rst_reload");

        // Contention right after reset: req0 first, held req1 next IDLE.
        SYS_reset_n = 1'b0;
        tick();
        SYS_reset_n = 1'b1;
        tick();
        a = mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        b = mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h000000DE, 1'b0);
        drive(a); drive(b);
        wait_gnt(2'b01, 1, "cont1_first");
        accept(a, "cont1_first");
        wait_gnt(2'b10, 3, "cont1_second");
        accept(b, "cont1_second");
        tick(); tick();

        // req1 served last: req0 wins again.
        drive(a); drive(b);
        wait_gnt(2'b01, 1, "cont2_first");
        accept(a, "cont2_first");
        wait_gnt(2'b10, 3, "cont2_second");
        accept(b, "cont2_second");
        tick(); tick();

        // req0 served alone, then contention: req1 wins.
        run_vec(a, "solo0");
        drive(a); drive(b);
        wait_gnt(2'b10, 1, "cont3_first");
        accept(b, "cont3_first");
        wait_gnt(2'b01, 3, "cont3_second");
        accept(a, "cont3_second");
        tick(); tick(); tick();

        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port byte-addressed data memory between two requesters: requester 0 (core load/store unit) and requester 1 (debug/preload loader). Arbitrates round-robin, latches one command, drives the memory's read/write controls for exactly one access cycle, and returns registered read data with a one-cycle valid pulse. Sits between the requesters and the data memory, on the same clock.

## Interface
Parameters:
- MEM_DEPTH, 100, memory size in bytes; used for the range check.
- N_REQ, 2, requester count; fixed at 2, vector ports are indexed by requester id.

Ports:
- SYS_clk  input  1  clock, all state on rising edge.
- SYS_reset_n  input  1  asynchronous, active-low reset.
- REQ_valid  input  2  request per requester; held until its grant.
- REQ_we  input  2  1 = store, 0 = load.
- REQ_len  input  4  2 bits per requester: 01 byte, 10 half, 11 word; 00 invalid.
- REQ_signed  input  2  load sign-extension select.
- REQ_addr  input  64  32-bit byte address per requester.
- REQ_wdata  input  64  32-bit store data per requester, right-justified.
- REQ_gnt  output  2  one-cycle pulse: command accepted.
- RSP_valid  output  2  one-cycle pulse: access complete.
- RSP_rdata  output  32  load data, valid with RSP_valid; 0 for stores/errors.
- RSP_err  output  1  access rejected, valid with RSP_valid.
- MEM_read_address, MEM_write_address  output  32  latched address.
- MEM_read_length, MEM_write_length  output  2  access size; 00 = no access.
- MEM_read_signed  output  1  latched signed flag.
- MEM_write_data  output  32  latched store data.
- MEM_read_data  input  32  combinational memory read result.

## Operation
- FSM IDLE -> ACCESS -> RESP -> IDLE; exactly three states.
- IDLE: if any REQ_valid, pick winner; latch we/len/signed/addr/wdata and winner id; set REQ_gnt[w] next cycle; go ACCESS. No request: stay IDLE.
- Round-robin: the requester not served last wins on contention; single requester always wins. last_served resets to 1, so requester 0 wins first contention.
- ACCESS: REQ_gnt[w]=1. Store: MEM_write_length=len (write at end of cycle). Load: MEM_read_length=len, capture MEM_read_data into rdata register at end of cycle.
- RESP: RSP_valid[w]=1, RSP_rdata = captured data (0 for stores), RSP_err per check; update last_served=w; go IDLE.
- MEM_write_length and MEM_read_length are 00 in every state except ACCESS. Address/data outputs hold latched values.
- Reset: state IDLE, all outputs and registers 0, last_served=1. Reset asserted during ACCESS drops MEM_write_length to 00 immediately; no write occurs, no response issued.

## Timing
- Request sampled at edge E0 -> REQ_gnt in cycle E0..E1 -> memory access same cycle -> RSP_valid in E1..E2. Latency 2 cycles from sampling edge to response; throughput one access per 3 cycles.
- Requester may change command/drop REQ_valid after seeing REQ_gnt; a loser keeps REQ_valid high and is served next IDLE.
- A REQ_valid held high through RESP is re-arbitrated in IDLE (no bypass).

## Configuration
- DMEM_ARB_CHECK_EN defined: command rejected if len=00, half with addr[0]=1, word with addr[1:0]!=00, or addr+bytes > MEM_DEPTH. Rejected: ACCESS drives both lengths 00, RSP_err=1, RSP_rdata=0; FSM timing unchanged.
- Undefined: no checks, RSP_err tied 0, every command forwarded as-is.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, ACCESS, RESP), length constants LEN_NONE=2'b00, LEN_BYTE=2'b01, LEN_HALF=2'b10, LEN_WORD=2'b11, byte-count function.
- Sub-module dmem_arb_rr: 2-way round-robin pick from REQ_valid and last_served, combinational.

## Test plan
- Req0 store word 0xDEADBEEF @0x10, then req0 load word @0x10 -> gnt one cycle after sample, MEM_write_length=11 only in ACCESS, load RSP_rdata=0xDEADBEEF two cycles after sample.
- Both request same cycle after reset -> req0 granted first, req1 granted in next IDLE; then both again -> req0 wins (alternation).
- Load byte signed @0x10 after above -> RSP_rdata=0xFFFFFFDE; unsigned -> 0x000000DE.
- With DMEM_ARB_CHECK_EN: word store @0x11 and store @98 word -> RSP_err=1, memory unchanged, no MEM_write_length pulse.
- Assert SYS_reset_n low during ACCESS of store -> MEM_write_length 00 immediately, no RSP_valid, target bytes unchanged, outputs all 0.
